// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick_gen divider bank.
package tick_gen_pkg;

    // Default input clock frequency in Hz (one channel period of 1 s).
    localparam int DEFAULT_F_CLK = 50_000_000;

    // Smallest legal period; smaller divisors are clamped up to this.
    localparam int MIN_DIV = 2;

    // Width of a channel index, never less than one bit.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One divider channel: counter, active period, shadow divisor with a
// pending flag, and registered square-wave / tick outputs.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int CNT_W    = 27,
    parameter int DIV_INIT = DEFAULT_F_CLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
    output logic             clk_slow,
    output logic             one_pulse
);

    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] DIV_RST =
        CNT_W'((DIV_INIT < MIN_DIV) ? MIN_DIV : DIV_INIT);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] per, per_n;
    logic [CNT_W-1:0] shadow, shadow_n;
    logic             pend_n;
    logic             en_d;
    logic             zero;
    logic [CNT_W:0]   half_n;
    logic             slow_n, pulse_n;

    // Next-state: counting, restarts, period hand-over and outputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path holds an old value and no latch is inferred.
        cnt_n    = cnt;
        per_n    = per;
        shadow_n = shadow;
        pend_n   = pending;
        zero     = 1'b0;

        if (!en) begin
            // Idle channel: counter parked, period may change at once.
            cnt_n = '0;
            if (wr) begin
                per_n = clamp_div(wr_div);
            end else if (pending) begin
                per_n  = shadow;
                pend_n = 1'b0;
            end
        end else begin
            if (!en_d || sync) begin
                cnt_n = '0;
                zero  = 1'b1;
            end else if (step) begin
                if (cnt == per - 1'b1) begin
                    cnt_n = '0;
                    zero  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            // A queued period only takes over on a fresh cycle start.
            if (zero && pending) begin
                per_n  = shadow;
                pend_n = 1'b0;
            end
            // Writes while running always queue, even on a wrap edge.
            if (wr) begin
                shadow_n = clamp_div(wr_div);
                pend_n   = 1'b1;
            end
        end

        // High phase is ceil(P/2) steps, so odd periods favour high.
        half_n  = ({1'b0, per_n} + 1'b1) >> 1;
        slow_n  = en && ({1'b0, cnt_n} < half_n);
        pulse_n = en && zero;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt       <= '0;
            per       <= DIV_RST;
            shadow    <= DIV_RST;
            pending   <= 1'b0;
            en_d      <= 1'b0;
            clk_slow  <= 1'b0;
            one_pulse <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            per       <= per_n;
            shadow    <= shadow_n;
            pending   <= pend_n;
            en_d      <= en;
            clk_slow  <= slow_n;
            one_pulse <= pulse_n;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick / slow-clock generator.
// Optional shared prescaler enabled by defining TICK_GEN_PRESCALER_EN.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int F_CLK    = DEFAULT_F_CLK,
    parameter int N_CH     = 4,
    parameter int CNT_W    = 27,
    parameter int DIV_INIT = F_CLK,
    parameter int PRE_DIV  = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             en,
    input  logic                        sync,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(N_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]            cfg_div,
    output logic [N_CH-1:0]             clk_slow,
    output logic [N_CH-1:0]             one_pulse
);

    localparam int CH_W = ch_idx_w(N_CH);

    logic [N_CH-1:0] pending;
    logic            wr_acc;
    logic            step;

`ifdef TICK_GEN_PRESCALER_EN
    localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;

    // Shared free-running prescaler; step fires once every PRE_DIV clocks.
    always_ff @(posedge clk) begin
        if (rst || pre_cnt == PRE_W'(PRE_DIV - 1)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign step = (pre_cnt == PRE_W'(PRE_DIV - 1));
`else
    assign step = 1'b1;
`endif

    // A channel with a queued period blocks further writes; an
    // out-of-range index is always ready and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    assign wr_acc = cfg_valid && cfg_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_gen_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .step      (step),
            .en        (en[i]),
            .sync      (sync),
            .wr        (wr_acc && (cfg_ch == CH_W'(i))),
            .wr_div    (cfg_div),
            .pending   (pending[i]),
            .clk_slow  (clk_slow[i]),
            .one_pulse (one_pulse[i])
        );
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter F_CLK, default 50000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4, meaning number of independent divider channels (1..16).
REQ-003 SHALL have parameter CNT_W, default 27, meaning divisor/counter width in bits.
REQ-004 SHALL have parameter DIV_INIT, default F_CLK, meaning per-channel period in clk cycles after reset (1 Hz).
REQ-005 SHALL have parameter PRE_DIV, default 1000, meaning prescaler ratio; used only when TICK_GEN_PRESCALER_EN is defined.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, N_CH, per-channel run enable.
REQ-009 SHALL have port sync, input, 1, one-cycle phase-align strobe for all enabled channels.
REQ-010 SHALL have port cfg_valid, input, 1, divisor write request.
REQ-011 SHALL have port cfg_ready, output, 1, divisor write can be accepted.
REQ-012 SHALL have port cfg_ch, input, max(1,$clog2(N_CH)), target channel of write.
REQ-013 SHALL have port cfg_div, input, CNT_W, new period P in counter steps.
REQ-014 SHALL have port clk_slow, output, N_CH, per-channel square wave, registered.
REQ-015 SHALL have port one_pulse, output, N_CH, per-channel one-clk tick, registered.

Function
REQ-016 Each channel SHALL hold counter cnt (0..P-1), active period P, shadow divisor and pending flag.
REQ-017 Enabled channel SHALL advance cnt by 1 per step (every clk), wrapping P-1 -> 0.
REQ-018 one_pulse[i] SHALL be high for exactly one clk in each cycle where cnt[i] becomes 0 by an advance, sync or enable start; never wider than one clk.
REQ-019 clk_slow[i] SHALL be 1 while cnt[i] < ceil(P/2), else 0; odd P gives the extra cycle to the high phase.
REQ-020 en[i] rising sampled at edge t SHALL load cnt=0, giving one_pulse[i]=1 and clk_slow[i]=1 in cycle t+1.
REQ-021 en[i] low SHALL hold cnt=0, clk_slow[i]=0, one_pulse[i]=0 starting the next cycle.
REQ-022 sync SHALL force cnt=0 on every enabled channel next cycle (one_pulse asserted); disabled channels unaffected.
REQ-023 Write accepted on cfg_valid && cfg_ready; cfg_div < 2 SHALL be clamped to 2; cfg_ch >= N_CH SHALL be accepted and discarded.
REQ-024 Accepted write to an enabled channel SHALL go to shadow and set pending; P SHALL update only at the next wrap or sync (glitch-free period change).
REQ-025 Accepted write to a disabled channel SHALL update P immediately, pending not set.
REQ-026 cfg_ready SHALL be combinational: !pending[cfg_ch]; a second write to a pending channel is stalled.
REQ-027 Wrap or sync coinciding with pending SHALL apply shadow to P and clear pending in that edge; new P governs clk_slow from cnt=0.
REQ-028 Write and wrap on same edge with no pending SHALL set pending; applies at following wrap.

Reset
REQ-029 On rst: cnt=0, P=DIV_INIT clamped to >=2, pending=0, clk_slow=0, one_pulse=0, prescaler=0; cfg_ready=1 from next cycle.
REQ-030 rst mid-period SHALL discard pending writes; en high after rst restarts per REQ-020.

Configuration
REQ-031 With TICK_GEN_PRESCALER_EN defined, a shared counter SHALL produce step enable every PRE_DIV clk; channels advance only on step; one_pulse remains one clk wide; en/sync/cfg remain clk-cycle responsive.
REQ-032 Without TICK_GEN_PRESCALER_EN, no prescaler logic SHALL exist; step is every clk; PRE_DIV ignored.

Structure
REQ-033 Package tick_gen_pkg SHALL hold the divisor-clamp constant (MIN_DIV=2), channel index width function, and default F_CLK.
REQ-034 Sub-module tick_gen_ch SHALL implement one channel (cnt, P, shadow, pending, outputs), instantiated N_CH times by generate.

Verification
REQ-035 P=4 ch0, en[0] high at edge 0 -> one_pulse[0] cycles 1,5,9; clk_slow[0] high 1-2, low 3-4.
REQ-036 P=5 -> clk_slow high 3 clk, low 2 clk; one_pulse period 5.
REQ-037 ch0 P=4 running, write 6 at cnt=1 -> cfg_ready low until wrap; next period 6; no truncated high phase.
REQ-038 ch0 P=4, ch1 P=7 desynchronised, sync at cycle 20 -> both one_pulse high cycle 21, periods continue 4/7.
REQ-039 cfg_div=0 to disabled ch2 -> P=2, immediate; enable -> toggle every clk, pulse every 2 clk.
REQ-040 rst at cycle 13 with pending write -> all outputs 0 next cycle, P=DIV_INIT, cfg_ready=1; with PRESCALER_EN, PRE_DIV=3, P=2 -> one_pulse every 6 clk.
